// File: rtl/imem_fetch_ctrl_if.sv
// IF-stage and Wishbone-classic bus bundle for imem_fetch_ctrl.
// The master modport is the fetch controller side; slave is the IF stage plus memory side.
interface imem_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              iEn;
  logic              iInval;
  logic [ADDR_W-1:0] iAddr;
  logic [31:0]       oData;
  logic              oStall;
  logic              oFault;
  logic              oWB_CYC;
  logic              oWB_STB;
  logic              oWB_WE;
  logic [3:0]        oWB_SEL;
  logic [ADDR_W-1:0] oWB_ADR;
  logic [31:0]       iWB_DAT;
  logic              iWB_ACK;
  logic              iWB_ERR;

  modport master (
    input  iEn, iInval, iAddr, iWB_DAT, iWB_ACK, iWB_ERR,
    output oData, oStall, oFault, oWB_CYC, oWB_STB, oWB_WE, oWB_SEL, oWB_ADR
  );

  modport slave (
    output iEn, iInval, iAddr, iWB_DAT, iWB_ACK, iWB_ERR,
    input  oData, oStall, oFault, oWB_CYC, oWB_STB, oWB_WE, oWB_SEL, oWB_ADR
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Wishbone-classic instruction-fetch master with a single held word.
// Define IMEM_FETCH_TIMEOUT_EN to abort a REQ after TIMEOUT cycles as a bus fault.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000013,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   iClk,
  input  logic                   nRst,
  imem_fetch_ctrl_if.master      bus
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e            state_q;
  logic              cyc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [31:0]       hold_data_q;
  logic              hold_valid_q;
  logic              hold_fault_q;
  logic              hit;
  logic              misalign;
  logic              expire;

`ifdef IMEM_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  assign hit      = hold_valid_q && (hold_addr_q == bus.iAddr);
  assign misalign = (bus.iAddr[1:0] != 2'b00);

  assign bus.oStall  = bus.iEn && !hit && !misalign;
  assign bus.oData   = misalign ? NOP_WORD : hold_data_q;
  assign bus.oFault  = misalign ? 1'b1     : hold_fault_q;
  assign bus.oWB_CYC = cyc_q;
  assign bus.oWB_STB = cyc_q;
  assign bus.oWB_WE  = 1'b0;
  assign bus.oWB_SEL = '1;
  assign bus.oWB_ADR = req_addr_q;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      req_addr_q   <= '0;
      hold_addr_q  <= '0;
      hold_data_q  <= NOP_WORD;
      hold_valid_q <= 1'b0;
      hold_fault_q <= 1'b0;
`ifdef IMEM_FETCH_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.iEn && !hit && !misalign) begin
            req_addr_q <= {bus.iAddr[ADDR_W-1:2], 2'b00};
            cyc_q      <= 1'b1;
            state_q    <= REQ;
`ifdef IMEM_FETCH_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        REQ: begin
          // Priority: ERR, then ACK, then timeout expiry.
          if (bus.iWB_ERR || (!bus.iWB_ACK && expire)) begin
            hold_data_q  <= NOP_WORD;
            hold_addr_q  <= req_addr_q;
            hold_valid_q <= 1'b1;
            hold_fault_q <= 1'b1;
            cyc_q        <= 1'b0;
            state_q      <= IDLE;
          end else if (bus.iWB_ACK) begin
            hold_data_q  <= bus.iWB_DAT;
            hold_addr_q  <= req_addr_q;
            hold_valid_q <= 1'b1;
            hold_fault_q <= 1'b0;
            cyc_q        <= 1'b0;
            state_q      <= IDLE;
          end
`ifdef IMEM_FETCH_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // Placed last so an invalidate overrides a fill landing in the same cycle.
      if (bus.iInval) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Wishbone-classic instruction-fetch master directly upstream of the IF pipeline register. Accepts the PC each cycle and returns the instruction word. Holds the last fetched word so a stalled or repeated PC is served without a new bus cycle. Drives the fetch-stall signal consumed by the IF stage, and reports bus faults.

Parameters:
ADDR_W, 32, address width (byte address)
NOP_WORD, 32'h00000013, word returned on fault/misalign (RV32I addi x0,x0,0)
TIMEOUT, 16, max cycles in REQ before abort (used only with macro)

Ports:
iClk  in  1  clock
nRst  in  1  async active-low reset
iEn  in  1  fetch enable (IF passes iEn & ~pipeline stall)
iInval  in  1  invalidate held word (flush / fence.i)
iAddr  in  ADDR_W  PC to fetch
oData  out  32  instruction word for iAddr
oStall  out  1  word for iAddr not yet available
oFault  out  1  oData is a fault substitute (err/misalign/timeout)
oWB_CYC  out  1  Wishbone cycle
oWB_STB  out  1  Wishbone strobe
oWB_WE  out  1  tied 0
oWB_SEL  out  4  tied 4'hF
oWB_ADR  out  ADDR_W  request address, word-aligned
iWB_DAT  in  32  read data
iWB_ACK  in  1  acknowledge
iWB_ERR  in  1  bus error

Behaviour:
- Reset is asynchronous on nRst low, clock iClk. All registers clear: state=IDLE, hold_valid=0, hold_addr=0, hold_data=NOP_WORD, hold_fault=0, timeout counter=0.
- Outputs after reset: oWB_CYC=oWB_STB=0, oWB_ADR=0, oData=NOP_WORD, oFault=0, oStall=iEn (combinational).
- hit = hold_valid & (hold_addr == iAddr). misalign = iAddr[1:0] != 0.
- oStall (combinational) = iEn & ~hit & ~misalign.
- oData/oFault (combinational) = misalign ? NOP_WORD/1 : hold_data/hold_fault.
- FSM states IDLE, REQ.
- IDLE: oWB_CYC=oWB_STB=0.
  - iEn & ~hit & ~misalign: latch req_addr = {iAddr[ADDR_W-1:2],2'b00}, clear counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ: oWB_CYC=oWB_STB=1, oWB_ADR=req_addr. Address is stable for the whole cycle.
  - iWB_ACK: hold_data=iWB_DAT, hold_addr=req_addr, hold_valid=1, hold_fault=0, go to IDLE.
  - iWB_ERR (ACK not set): hold_data=NOP_WORD, hold_addr=req_addr, hold_valid=1, hold_fault=1, go to IDLE.
  - ACK and ERR both high: ERR wins.
- Latency on a miss, zero-wait slave (ACK in first REQ cycle):
  - cycle 0: miss detected, oStall=1.
  - cycle 1: REQ, ACK received.
  - cycle 2: hit, oStall=0, word on oData.
  - Each extra slave wait state adds one cycle.
- iAddr changing while in REQ: the transaction completes for the latched req_addr. The resulting hold entry does not match the new iAddr, so a new REQ is issued from IDLE. There is no mid-cycle abort.
- iEn low: no new request is started. An outstanding REQ still completes. oStall=0.
- iInval: clears hold_valid the next cycle.
  - iInval in the same cycle as ACK: the invalidate wins and hold_valid=0. The data is still written.
- Misaligned iAddr never generates a bus cycle.
- Reset asserted mid-REQ: CYC/STB drop asynchronously and the hold entry clears. The slave must tolerate a dropped cycle.

Optional Feature:
Macro IMEM_FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle in REQ.
  - When it reaches TIMEOUT-1 without ACK/ERR, the FSM behaves as on ERR: NOP_WORD, hold_fault=1, go to IDLE, CYC dropped.
  - ACK arriving in the same cycle as expiry takes priority over the timeout.
- Undefined: no counter logic; REQ waits indefinitely and TIMEOUT is ignored.

Test Plan:
- Reset release, iEn=1, iAddr=0x0, slave ACK in first REQ cycle with DAT=0x00500093 -> oStall=1 for 2 cycles, then oData=0x00500093, oFault=0, exactly one CYC.
- Held iAddr=0x0 for 10 cycles after fill -> no further CYC, oStall=0 throughout.
- Sequence 0x0, 0x4, 0x8, each with 2 slave wait states -> 4 stall cycles per address, oWB_ADR matches each PC, data returned in order.
- iAddr=0x6 -> oStall=0, oData=0x00000013, oFault=1, CYC never asserted.
- iWB_ERR on fetch of 0x10 -> oData=0x00000013, oFault=1, then iInval -> refetch of 0x10 issued, ACK DAT=0x00000073 -> oFault=0.
- With IMEM_FETCH_TIMEOUT_EN and TIMEOUT=4, slave never responds -> CYC high exactly 4 cycles, then oFault=1, oData=NOP; without the macro CYC stays high.
